// File: rtl/memory_arbiter_if.sv
// Request/response bundle between the datapath requesters, the arbiter and
// the single-ported RAM model. The arbiter takes the slave view; whoever
// drives the requests and models the RAM takes the master view.
interface memory_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Datapath request side
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              ihit;
  logic [DATA_W-1:0] iload;
  logic              dhit;
  logic [DATA_W-1:0] dload;

  // RAM side
  logic              ram_ren;
  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic [DATA_W-1:0] ram_load;
  logic              ram_ready;

  // Status
  logic              mem_err;
  logic [31:0]       icount;
  logic [31:0]       dcount;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    output ihit, iload, dhit, dload, ram_ren, ram_wen, ram_addr, ram_store,
           mem_err, icount, dcount
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_load, ram_ready,
    input  ihit, iload, dhit, dload, ram_ren, ram_wen, ram_addr, ram_store,
           mem_err, icount, dcount
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: serves instruction fetches and data loads/stores against a
// single-ported RAM. One access is in flight at a time; the granted request is
// latched so the RAM sees a stable address/data until ram_ready (or timeout).
// Completion is a one-cycle ihit/dhit with the load word passed straight
// through from ram_load. All RAM strobes and hits decode from the state
// register, so an asynchronous reset removes them without waiting for a clock.
//
// Optional build macro: MEM_ARBITER_STATS_EN adds 32-bit completed-access
// counters (icount/dcount); without it both read 0 and no counter flops exist.
module memory_arbiter #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              TIMEOUT  = 64,
  parameter logic [DATA_W-1:0] ERR_WORD = 32'hBAD1BAD1
) (
  input  logic               CLK,
  input  logic               nRST,
  memory_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  // Counter only has to reach TIMEOUT-1; keep at least one bit when disabled.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic              wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_err_q, mem_err_d;

  logic              ram_ren;
  logic              ram_wen;
  logic              ihit;
  logic              dhit;
  logic [DATA_W-1:0] iload;
  logic [DATA_W-1:0] dload;
  logic              timed_out;
  logic              done;
  logic [DATA_W-1:0] hit_word;
  logic              data_req;

  // Completion decode shared by both access states: a real RAM response wins
  // over a timeout landing in the same cycle.
  always_comb begin
    timed_out = TIMEOUT_EN && !bus.ram_ready && (cnt_q == CNT_LAST);
    done      = bus.ram_ready || timed_out;
    hit_word  = bus.ram_ready ? bus.ram_load : ERR_WORD;
    data_req  = bus.dREN || bus.dWEN;
  end

  // Next-state, grant, request latching and per-state outputs.
  // NOTE: every variable gets its default before the case so no path leaves
  // one unassigned; a missed default here would infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    store_d      = store_q;
    wr_d         = wr_q;
    cnt_d        = cnt_q;
    mem_err_d    = mem_err_q;
    ram_ren      = 1'b0;
    ram_wen      = 1'b0;
    ihit         = 1'b0;
    dhit         = 1'b0;
    iload        = '0;
    dload        = '0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Data wins a tie unless it was also the last grant, which gives
        // strict alternation under contention and keeps fetches from starving.
        if (data_req && (last_grant_q == GRANT_I || !bus.iREN)) begin
          state_d      = DACC;
          last_grant_d = GRANT_D;
          addr_d       = bus.daddr;
          store_d      = bus.dstore;
          wr_d         = bus.dWEN;
        end else if (bus.iREN) begin
          state_d      = IACC;
          last_grant_d = GRANT_I;
          addr_d       = bus.iaddr;
          wr_d         = 1'b0;
        end
      end

      IACC: begin
        ram_ren = 1'b1;
        if (done) begin
          ihit    = 1'b1;
          iload   = hit_word;
          state_d = IDLE;
          if (timed_out) mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DACC: begin
        ram_wen = wr_q;
        ram_ren = !wr_q;
        if (done) begin
          dhit    = 1'b1;
          dload   = hit_word;
          state_d = IDLE;
          if (timed_out) mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers; reset returns to IDLE with last grant INSTR.
  // NOTE: registers take non-blocking assignments so every flop samples the
  // values from before this edge regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      addr_q       <= '0;
      store_q      <= '0;
      wr_q         <= 1'b0;
      cnt_q        <= '0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      store_q      <= store_d;
      wr_q         <= wr_d;
      cnt_q        <= cnt_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign bus.ram_ren   = ram_ren;
  assign bus.ram_wen   = ram_wen;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_store = store_q;
  assign bus.ihit      = ihit;
  assign bus.iload     = iload;
  assign bus.dhit      = dhit;
  assign bus.dload     = dload;
  assign bus.mem_err   = mem_err_q;

`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] icount_q, icount_d;
  logic [31:0] dcount_q, dcount_d;

  // Completed-access counters, timeout hits included; wrap modulo 2^32.
  always_comb begin
    icount_d = icount_q + {31'b0, ihit};
    dcount_d = dcount_q + {31'b0, dhit};
  end

  // Counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount_q <= '0;
      dcount_q <= '0;
    end else begin
      icount_q <= icount_d;
      dcount_q <= dcount_d;
    end
  end

  assign bus.icount = icount_q;
  assign bus.dcount = dcount_q;
`else
  assign bus.icount = '0;
  assign bus.dcount = '0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: reset, lone fetch, write precedence,
// alternation under contention, timeout, mid-access reset and access counters.
module tb_memory_arbiter;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  memory_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8),
    .ERR_WORD(32'hBAD1BAD1)
  ) dut (
    .CLK (clk),
    .nRST(nrst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Single uncontended access from IDLE; RAM answers in the first cycle.
  task automatic do_access(input string tag, input bit is_d, input bit is_w,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] word);
    if (is_d) begin
      bus.dREN   = !is_w;
      bus.dWEN   = is_w;
      bus.daddr  = addr;
      bus.dstore = wdata;
    end else begin
      bus.iREN  = 1'b1;
      bus.iaddr = addr;
    end
    cyc();
    check({tag, "_ren"},  bus.ram_ren, !(is_d && is_w));
    check({tag, "_wen"},  bus.ram_wen, is_d && is_w);
    check({tag, "_addr"}, bus.ram_addr, addr);
    bus.ram_ready = 1'b1;
    bus.ram_load  = word;
    bus.iREN = 1'b0;
    bus.dREN = 1'b0;
    bus.dWEN = 1'b0;
    #1;
    check({tag, "_hit"}, is_d ? bus.dhit : bus.ihit, 1);
    if (!is_w) check({tag, "_load"}, is_d ? bus.dload : bus.iload, word);
    cyc();
    bus.ram_ready = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        exp_d;
    logic [31:0] exp_addr;
    logic [31:0] word;
    logic [31:0] exp_icnt;
    logic [31:0] exp_dcnt;

    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ram_load = 0; bus.ram_ready = 0;

    // Reset state
    #12;
    check("rst_ram_ren", bus.ram_ren, 0);
    check("rst_ram_wen", bus.ram_wen, 0);
    check("rst_ihit",    bus.ihit, 0);
    check("rst_dhit",    bus.dhit, 0);
    check("rst_mem_err", bus.mem_err, 0);
    check("rst_addr",    bus.ram_addr, 0);
    check("rst_icount",  bus.icount, 0);
    @(negedge clk);
    nrst = 1'b1;
    cyc();

    // Lone fetch, RAM ready two cycles after ram_ren rises
    bus.iREN = 1; bus.iaddr = 32'h100;
    cyc();
    check("f_ren",  bus.ram_ren, 1);
    check("f_addr", bus.ram_addr, 32'h100);
    check("f_ihit_wait0", bus.ihit, 0);
    cyc();
    check("f_ihit_wait1", bus.ihit, 0);
    check("f_ren_held",   bus.ram_ren, 1);
    cyc();
    bus.ram_ready = 1; bus.ram_load = 32'h2408000A; bus.iREN = 0;
    #1;
    check("f_ihit",  bus.ihit, 1);
    check("f_iload", bus.iload, 32'h2408000A);
    check("f_dhit",  bus.dhit, 0);
    cyc();
    bus.ram_ready = 0;
    #1;
    check("f_ihit_pulse", bus.ihit, 0);
    check("f_ren_idle",   bus.ram_ren, 0);

    // Write precedence: dREN and dWEN together is a write
    bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h40; bus.dstore = 32'hDEADBEEF;
    cyc();
    check("w_wen",   bus.ram_wen, 1);
    check("w_ren",   bus.ram_ren, 0);
    check("w_store", bus.ram_store, 32'hDEADBEEF);
    check("w_addr",  bus.ram_addr, 32'h40);
    bus.daddr = 32'h44; bus.dstore = 32'h12345678; bus.dWEN = 0;
    #1;
    check("w_store_stable", bus.ram_store, 32'hDEADBEEF);
    check("w_wen_stable",   bus.ram_wen, 1);
    bus.ram_ready = 1; bus.ram_load = 32'h0; bus.dREN = 0;
    #1;
    check("w_dhit", bus.dhit, 1);
    check("w_ihit", bus.ihit, 0);
    cyc();
    bus.ram_ready = 0;
    #1;
    check("w_dhit_pulse", bus.dhit, 0);
    check("w_wen_idle",   bus.ram_wen, 0);

    // Contention after a data grant: I, D, I, D, I, D
    bus.iREN = 1; bus.iaddr = 32'h200;
    bus.dREN = 1; bus.dWEN = 0; bus.daddr = 32'h80;
    for (int k = 0; k < 6; k++) begin
      exp_d    = (k % 2) == 1;
      exp_addr = (exp_d ? 32'h80 : 32'h200) + 32'(4 * (k / 2));
      word     = 32'hA0000000 + 32'(k);
      cyc();
      check("alt_ren",  bus.ram_ren, 1);
      check("alt_wen",  bus.ram_wen, 0);
      check("alt_addr", bus.ram_addr, exp_addr);
      bus.ram_ready = 1;
      bus.ram_load  = word;
      if (exp_d) begin
        if (k == 5) bus.dREN = 0;
        else        bus.daddr = bus.daddr + 32'd4;
      end else begin
        if (k == 4) bus.iREN = 0;
        else        bus.iaddr = bus.iaddr + 32'd4;
      end
      #1;
      check("alt_ihit", bus.ihit, !exp_d);
      check("alt_dhit", bus.dhit, exp_d);
      check("alt_load", exp_d ? bus.dload : bus.iload, word);
      cyc();
      // ram_ready still high in IDLE must not produce a hit
      check("idle_ready_ignored", {bus.ihit, bus.dhit}, 0);
      bus.ram_ready = 0;
    end

    // Timeout: RAM never ready, dhit in the eighth cycle after grant
    check("to_mem_err_before", bus.mem_err, 0);
    bus.dREN = 1; bus.daddr = 32'h300;
    cyc();
    for (int c = 1; c < 8; c++) begin
      check("to_dhit_early", bus.dhit, 0);
      check("to_ren_held",   bus.ram_ren, 1);
      cyc();
    end
    bus.dREN = 0;
    #1;
    check("to_dhit",  bus.dhit, 1);
    check("to_dload", bus.dload, 32'hBAD1BAD1);
    cyc();
    check("to_mem_err",    bus.mem_err, 1);
    check("to_dhit_pulse", bus.dhit, 0);
    check("to_ren_idle",   bus.ram_ren, 0);
    do_access("post_to_fetch", 0, 0, 32'h400, 32'h0, 32'h13579BDF);
    check("to_mem_err_sticky", bus.mem_err, 1);

`ifdef MEM_ARBITER_STATS_EN
    exp_icnt = 32'd5;
    exp_dcnt = 32'd5;
`else
    exp_icnt = 32'd0;
    exp_dcnt = 32'd0;
`endif
    check("cnt_pre_icount", bus.icount, exp_icnt);
    check("cnt_pre_dcount", bus.dcount, exp_dcnt);

    // Mid-access reset between clock edges during a write
    bus.dWEN = 1; bus.daddr = 32'h500; bus.dstore = 32'hCAFEF00D;
    cyc();
    bus.ram_ready = 1;
    #1;
    check("mr_wen_before",  bus.ram_wen, 1);
    check("mr_dhit_before", bus.dhit, 1);
    #1;
    nrst = 1'b0;
    #1;
    check("mr_wen",     bus.ram_wen, 0);
    check("mr_ren",     bus.ram_ren, 0);
    check("mr_dhit",    bus.dhit, 0);
    check("mr_mem_err", bus.mem_err, 0);
    check("mr_addr",    bus.ram_addr, 0);
    check("mr_store",   bus.ram_store, 0);
    check("mr_dcount",  bus.dcount, 0);
    bus.dWEN = 0; bus.ram_ready = 0;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    cyc();
    check("mr_idle_ren", bus.ram_ren, 0);
    check("mr_idle_wen", bus.ram_wen, 0);

    // Counters: three fetches and two data accesses after reset
    do_access("s_f0", 0, 0, 32'h600, 32'h0,        32'h00000011);
    do_access("s_d0", 1, 1, 32'h700, 32'h55AA55AA, 32'h0);
    do_access("s_f1", 0, 0, 32'h604, 32'h0,        32'h00000022);
    do_access("s_d1", 1, 0, 32'h704, 32'h0,        32'h00000033);
    do_access("s_f2", 0, 0, 32'h608, 32'h0,        32'h00000044);
`ifdef MEM_ARBITER_STATS_EN
    exp_icnt = 32'd3;
    exp_dcnt = 32'd2;
`else
    exp_icnt = 32'd0;
    exp_dcnt = 32'd0;
`endif
    check("s_icount", bus.icount, exp_icnt);
    check("s_dcount", bus.dcount, exp_dcnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
